// File: rtl/iir_pkg.sv
// iir_pkg -- shared definitions for the all-pole IIR filter.
//   iir_state_e  : controller states (IDLE, MAC, NORM, OUT)
//   acc_width()  : accumulator width that cannot wrap for a given W, FRAC, N
//   round_const(): half-LSB constant added before the final right shift
package iir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_NORM = 2'd2,
        ST_OUT  = 2'd3
    } iir_state_e;

    // x<<FRAC needs W+FRAC bits, each product 2W bits, N products add
    // clog2(N) bits of growth; one extra bit covers the mixed-sign sum.
    function automatic int acc_width(input int w, input int frac, input int n);
        return w + frac + w + $clog2(n) + 1;
    endfunction

    function automatic longint round_const(input int frac);
        return longint'(1) << (frac - 1);
    endfunction

endpackage

// File: rtl/iir_round_sat.sv
// iir_round_sat -- combinational round-half-up and saturate.
//   acc      in   ACC_W  signed accumulator, FRAC fractional bits
//   sat_data out  W      signed rounded and clamped sample
//   sat_ovf  out  1      high when the clamp was applied
module iir_round_sat
    import iir_pkg::*;
#(
    parameter int W     = 16,
    parameter int FRAC  = 14,
    parameter int ACC_W = 51
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [W-1:0]     sat_data,
    output logic                    sat_ovf
);

    localparam logic signed [ACC_W-1:0] RND   = ACC_W'(round_const(FRAC));
    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

    logic signed [ACC_W-1:0] rounded;
    logic signed [ACC_W-1:0] shifted;

    // The accumulator has enough headroom that adding the half-LSB
    // cannot wrap; the arithmetic shift floors, so ties go toward +inf.
    assign rounded = acc + RND;
    assign shifted = rounded >>> FRAC;

    always_comb begin
        sat_data = shifted[W-1:0];
        sat_ovf  = 1'b0;
        if (shifted > MAX_V) begin
            sat_data = MAX_V[W-1:0];
            sat_ovf  = 1'b1;
        end else if (shifted < MIN_V) begin
            sat_data = MIN_V[W-1:0];
            sat_ovf  = 1'b1;
        end
    end

endmodule

// File: rtl/iir_allpole.sv
// iir_allpole -- sequential all-pole IIR:
//   y[n] = sat(round((x[n]<<FRAC - sum_k a[k]*y[n-1-k]) >> FRAC))
// One multiplier is shared across the N coefficients, one product per cycle.
//   clock, reset        clock and synchronous active-high reset
//   in_data/in_valid/in_ready     input sample stream
//   coef                N signed coefficients, read live during MAC
//   out_data/out_valid/out_ready  output sample stream
//   busy                controller is not idle
//   ovf                 sticky saturation flag
//   state_dbg           current controller state
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds data stable while valid is high and ready
// is low; out_valid never depends on out_ready, and in_ready and out_valid
// are never high together.
module iir_allpole
    import iir_pkg::*;
#(
    parameter int N    = 10,
    parameter int W    = 16,
    parameter int FRAC = 14
) (
    input  logic                clock,
    input  logic                reset,
    input  logic signed [W-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N-1:0][W-1:0] coef,
    output logic signed [W-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                ovf,
    output logic [1:0]          state_dbg
);

    localparam int ACC_W = acc_width(W, FRAC, N);
    localparam int K_W   = (N > 1) ? $clog2(N) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(N - 1);

    iir_state_e state_q, state_d;

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [K_W-1:0]          k_q, k_d;
    logic [N-1:0][W-1:0]     hist_q, hist_d;  // hist_q[k] holds y[n-1-k]
    logic signed [W-1:0]     out_data_q, out_data_d;
    logic                    ovf_q, ovf_d;

    logic signed [W-1:0]     mac_coef;
    logic signed [W-1:0]     mac_hist;
    logic signed [2*W-1:0]   product;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] x_ext;
    logic signed [W-1:0]     sat_data;
    logic                    sat_ovf;

    // Single shared multiplier, indexed by the MAC step counter.
    assign mac_coef = coef[k_q];
    assign mac_hist = hist_q[k_q];
    assign product  = mac_coef * mac_hist;
    assign prod_ext = {{(ACC_W-2*W){product[2*W-1]}}, product};
    assign x_ext    = {{(ACC_W-W){in_data[W-1]}}, in_data};

    iir_round_sat #(
        .W     (W),
        .FRAC  (FRAC),
        .ACC_W (ACC_W)
    ) u_round_sat (
        .acc      (acc_q),
        .sat_data (sat_data),
        .sat_ovf  (sat_ovf)
    );

    // State register and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            k_q        <= '0;
            hist_q     <= '0;
            out_data_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            k_q        <= k_d;
            hist_q     <= hist_d;
            out_data_q <= out_data_d;
            ovf_q      <= ovf_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)        state_d = ST_MAC;
            ST_MAC:  if (k_q == K_LAST)   state_d = ST_NORM;
            ST_NORM:                      state_d = ST_OUT;
            ST_OUT:  if (out_ready)       state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
    end

    // Outputs; handshake outputs are forced low while reset is asserted.
    always_comb begin
        in_ready  = (state_q == ST_IDLE) && !reset;
        out_valid = (state_q == ST_OUT) && !reset;
        busy      = (state_q != ST_IDLE) && !reset;
        out_data  = out_data_q;
        ovf       = ovf_q;
        state_dbg = state_q;
    end

    // Datapath next values.
    always_comb begin
        acc_d      = acc_q;
        k_d        = k_q;
        hist_d     = hist_q;
        out_data_d = out_data_q;
        ovf_d      = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    acc_d = x_ext <<< FRAC;
                    k_d   = '0;
                end
            end
            ST_MAC: begin
                acc_d = acc_q - prod_ext;
                k_d   = k_q + K_W'(1);
            end
            ST_NORM: begin
                out_data_d = sat_data;
                ovf_d      = ovf_q | sat_ovf;
            end
            ST_OUT: begin
                // History only advances once the output has been taken,
                // so an aborted sample never pollutes it.
                if (out_ready) begin
                    for (int i = N - 1; i > 0; i--) begin
                        hist_d[i] = hist_q[i-1];
                    end
                    hist_d[0] = out_data_q;
                end
            end
            default: begin
                acc_d = acc_q;
            end
        endcase
    end

endmodule

// File: tb/tb_iir_allpole.sv
// tb_iir_allpole -- directed bench for iir_allpole with a behavioural
// model checked on every output transfer.
module tb_iir_allpole;
    import iir_pkg::*;

    localparam int N    = 10;
    localparam int W    = 16;
    localparam int FRAC = 14;
    localparam longint SCALE = longint'(1) << FRAC;
    localparam longint MAXV  = (longint'(1) << (W - 1)) - 1;
    localparam longint MINV  = -(longint'(1) << (W - 1));

    // ---------------- clock / reset ----------------
    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic signed [W-1:0] in_data = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [N-1:0][W-1:0] coef = '0;
    logic signed [W-1:0] out_data;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic                busy;
    logic                ovf;
    logic [1:0]          state_dbg;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    iir_allpole #(.N(N), .W(W), .FRAC(FRAC)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .coef      (coef),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .ovf       (ovf),
        .state_dbg (state_dbg)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model / scoreboard ----------------
    logic [W-1:0]        exp_q[$];
    bit                  exp_ovf_q[$];
    longint              hist_m[N];
    bit                  ovf_m;
    bit                  held;
    logic signed [W-1:0] held_data;

    function automatic longint floor_div(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    always @(negedge clock) begin
        longint       num;
        longint       y;
        logic [W-1:0] e;
        bit           eo;
        if (reset) begin
            exp_q.delete();
            exp_ovf_q.delete();
            ovf_m = 1'b0;
            held  = 1'b0;
            for (int i = 0; i < N; i++) hist_m[i] = 0;
        end else begin
            check("in_ready_out_valid_exclusive", longint'(in_ready && out_valid), 0);
            if (in_valid && in_ready) begin
                num = longint'(in_data) * SCALE;
                for (int k = 0; k < N; k++) num = num - longint'($signed(coef[k])) * hist_m[k];
                y = floor_div(num + SCALE / 2, SCALE);
                if (y > MAXV) begin
                    y = MAXV;
                    ovf_m = 1'b1;
                end else if (y < MINV) begin
                    y = MINV;
                    ovf_m = 1'b1;
                end
                for (int k = N - 1; k > 0; k--) hist_m[k] = hist_m[k-1];
                hist_m[0] = y;
                exp_q.push_back(W'(y));
                exp_ovf_q.push_back(ovf_m);
            end
            if (out_valid) begin
                if (held) check("out_data_hold", out_data, held_data);
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 1, 0);
                    end else begin
                        e  = exp_q.pop_front();
                        eo = exp_ovf_q.pop_front();
                        check("out_data_model", out_data, longint'($signed(e)));
                        check("ovf_model", ovf, eo);
                    end
                    held = 1'b0;
                end else begin
                    held      = 1'b1;
                    held_data = out_data;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end at posedge+1 so they never race the monitor.
    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        check("rst_ovf", ovf, 0);
        check("rst_state", state_dbg, longint'(ST_IDLE));
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("in_ready_after_reset", in_ready, 1);
        @(posedge clock);
        #1;
    endtask

    task automatic set_a0(input int a0);
        coef    = '0;
        coef[0] = W'(a0);
    endtask

    task automatic send(input int x);
        int t = 0;
        in_data  = W'(x);
        in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            @(negedge clock);
            t++;
        end
        if (!in_ready) check("send_timeout", 0, 1);
        @(posedge clock);
        #1 in_valid = 1'b0;
    endtask

    task automatic recv(output longint y, output longint o);
        int t = 0;
        out_ready = 1'b1;
        while (!out_valid && t < 200) begin
            @(negedge clock);
            t++;
        end
        if (!out_valid) check("recv_timeout", 0, 1);
        y = out_data;
        o = ovf;
        @(posedge clock);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed tests ----------------
    initial begin
        int     pt_in[3]     = '{100, -5, 32767};
        int     pt_exp[3]    = '{100, -5, 32767};
        int     dec_in[6]    = '{16384, 0, 0, 0, 0, 0};
        int     dec_exp[6]   = '{16384, 8192, 4096, 2048, 1024, 512};
        int     sat_exp[3]   = '{30000, 32767, 32767};
        int     sat_ovf[3]   = '{0, 1, 1};
        int     acc_cyc[$];
        int     xfer_cyc[$];
        int     seen;
        int     t;
        longint y;
        longint o;

        do_reset();

        // Pass-through with zero feedback.
        coef = '0;
        for (int i = 0; i < 3; i++) begin
            send(pt_in[i]);
            recv(y, o);
            check("pass_data", y, pt_exp[i]);
            check("pass_ovf", o, 0);
        end

        // Geometric decay from a single pole at 0.5.
        do_reset();
        set_a0(-8192);
        for (int i = 0; i < 6; i++) begin
            send(dec_in[i]);
            recv(y, o);
            check("decay_data", y, dec_exp[i]);
        end

        // Saturation with a pole at 1.0; ovf must stick.
        do_reset();
        set_a0(-16384);
        for (int i = 0; i < 3; i++) begin
            send(30000);
            recv(y, o);
            check("sat_data", y, sat_exp[i]);
            check("sat_ovf", o, sat_ovf[i]);
        end
        repeat (5) @(posedge clock);
        #1 check("sat_ovf_sticky", ovf, 1);

        // Backpressure: output held, waiting input not consumed.
        do_reset();
        coef      = '0;
        out_ready = 1'b0;
        send(1234);
        in_data  = W'(-4321);
        in_valid = 1'b1;
        t = 0;
        while (!out_valid && t < 200) begin
            @(negedge clock);
            t++;
            if (!out_valid) check("bp_in_ready_busy", in_ready, 0);
        end
        check("bp_out_valid", out_valid, 1);
        check("bp_first_data", out_data, 1234);
        repeat (5) begin
            @(negedge clock);
            check("bp_hold_data", out_data, 1234);
            check("bp_hold_valid", out_valid, 1);
            check("bp_in_ready_low", in_ready, 0);
        end
        @(posedge clock);
        #1 out_ready = 1'b1;
        @(negedge clock);
        check("bp_transfer", longint'(out_valid && out_ready), 1);
        @(negedge clock);
        check("bp_accept_after", longint'(in_ready && in_valid), 1);
        @(posedge clock);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        recv(y, o);
        check("bp_second_data", y, -4321);

        // Throughput and latency with both sides always ready.
        do_reset();
        coef      = '0;
        in_data   = W'(77);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        repeat (60) begin
            @(negedge clock);
            if (in_valid && in_ready) acc_cyc.push_back(cyc);
            if (out_valid && out_ready) xfer_cyc.push_back(cyc);
        end
        @(posedge clock);
        #1 in_valid = 1'b0;
        repeat (20) @(posedge clock);
        #1 out_ready = 1'b0;
        check("tp_accept_count", longint'(acc_cyc.size() >= 4), 1);
        check("tp_xfer_count", longint'(xfer_cyc.size() >= 3), 1);
        if (acc_cyc.size() >= 4 && xfer_cyc.size() >= 3) begin
            check("tp_first_latency", xfer_cyc[0] - acc_cyc[0], N + 2);
            check("tp_accept_period", acc_cyc[1] - acc_cyc[0], N + 3);
            check("tp_accept_period2", acc_cyc[3] - acc_cyc[2], N + 3);
            check("tp_out_period", xfer_cyc[1] - xfer_cyc[0], N + 3);
            check("tp_out_period2", xfer_cyc[2] - xfer_cyc[1], N + 3);
        end

        // Reset during MAC aborts the sample and clears history.
        do_reset();
        set_a0(-8192);
        send(16384);
        recv(y, o);
        check("abort_pre_data", y, 16384);
        send(16384);
        repeat (3) @(posedge clock);
        #1;
        do_reset();
        out_ready = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clock);
            if (out_valid) seen++;
        end
        check("abort_no_output", seen, 0);
        @(posedge clock);
        #1 out_ready = 1'b0;
        send(16384);
        recv(y, o);
        check("abort_history_cleared", y, 16384);

        repeat (3) @(posedge clock);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
